// File: rtl/mdu_if.sv
// EX <-> MDU handshake bundle: operation request from EX, stall/status and HI/LO back.
interface mdu_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stallreq;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op_code, src_a, src_b, flush,
    input  stallreq, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op_code, src_a, src_b, flush,
    output stallreq, busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer and HI/LO owner.
// Multiply: operands latched at accept, product committed after MUL_STAGES cycles.
// Divide: restoring shift-subtract on magnitudes, DIV_STEP quotient bits per cycle,
// sign fix-up and divide-by-zero override applied at commit.
module mdu_ctrl #(
  parameter int MUL_STAGES = 2,
  parameter int DIV_STEP   = 1
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [4:0] MUL_INIT = 5'(MUL_STAGES - 1);
  localparam logic [4:0] DIV_INIT = 5'((32 / DIV_STEP) - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;
  logic        busy_r, done_r;
  logic [31:0] hi_r, lo_r;

  logic        sgn_r;                 // signed operation (mult/div)
  logic [31:0] a_r, b_r;              // raw operands as accepted
  logic [31:0] rem_r, quo_r, dvs_r;   // divider working registers

  logic acc_mul_s, acc_div_s, div_run_s, commit_mul_s, commit_div_s;
  logic wr_hi_s, wr_lo_s;

  logic [31:0] rem_n_s, quo_n_s;
  logic [63:0] prod_s;
  logic [31:0] div_hi_s, div_lo_s;

  // One restoring step: shift in the next dividend bit, subtract divisor if it fits.
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] dvs);
    logic [32:0] sh;
    logic [32:0] diff;
    sh   = {rem, quo[31]};
    diff = sh - {1'b0, dvs};
    if (sh >= {1'b0, dvs}) begin
      return {diff[31:0], quo[30:0], 1'b1};
    end else begin
      return {sh[31:0], quo[30:0], 1'b0};
    end
  endfunction

  // Two's-complement magnitude, used only for signed operands.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      return (~v) + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // FSM state and iteration counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == ST_MUL) || (state_s == ST_DIV);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Next-state, counter and datapath enables; flush always wins.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    acc_mul_s    = 1'b0;
    acc_div_s    = 1'b0;
    div_run_s    = 1'b0;
    commit_mul_s = 1'b0;
    commit_div_s = 1'b0;
    wr_hi_s      = 1'b0;
    wr_lo_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.op_valid && !bus.flush) begin
          case (bus.op_code)
            OP_MULT, OP_MULTU: begin
              state_s   = ST_MUL;
              cnt_s     = MUL_INIT;
              acc_mul_s = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_s   = ST_DIV;
              cnt_s     = DIV_INIT;
              acc_div_s = 1'b1;
            end
            OP_MTHI: wr_hi_s = 1'b1;
            OP_MTLO: wr_lo_s = 1'b1;
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (bus.flush) begin
          state_s = ST_IDLE;
          cnt_s   = 5'd0;
        end else if (cnt_r == 5'd0) begin
          state_s      = ST_DONE;
          commit_mul_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 5'd1;
        end
      end
      ST_DIV: begin
        if (bus.flush) begin
          state_s = ST_IDLE;
          cnt_s   = 5'd0;
        end else if (cnt_r == 5'd0) begin
          state_s      = ST_DONE;
          div_run_s    = 1'b1;
          commit_div_s = 1'b1;
        end else begin
          div_run_s = 1'b1;
          cnt_s     = cnt_r - 5'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 5'd0;
      end
    endcase
  end

  // Divider iteration: DIV_STEP restoring steps chained per cycle.
  always_comb begin
    logic [63:0] t;
    rem_n_s = rem_r;
    quo_n_s = quo_r;
    t       = 64'd0;
    for (int i = 0; i < DIV_STEP; i++) begin
      t       = div_step(rem_n_s, quo_n_s, dvs_r);
      rem_n_s = t[63:32];
      quo_n_s = t[31:0];
    end
  end

  // Commit values: full product, and divide result with sign fix-up / zero-divisor override.
  always_comb begin
    logic [63:0] pa;
    logic [63:0] pb;
    pa     = sgn_r ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
    pb     = sgn_r ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
    prod_s = pa * pb;
    if (b_r == 32'd0) begin
      div_lo_s = 32'hFFFF_FFFF;
      div_hi_s = a_r;
    end else begin
      div_lo_s = (sgn_r && (a_r[31] ^ b_r[31])) ? ((~quo_n_s) + 32'd1) : quo_n_s;
      div_hi_s = (sgn_r && a_r[31]) ? ((~rem_n_s) + 32'd1) : rem_n_s;
    end
  end

  // Operand latch and divider working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_r <= 1'b0;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      rem_r <= 32'd0;
      quo_r <= 32'd0;
      dvs_r <= 32'd0;
    end else if (acc_mul_s || acc_div_s) begin
      sgn_r <= ~bus.op_code[0];
      a_r   <= bus.src_a;
      b_r   <= bus.src_b;
      rem_r <= 32'd0;
      quo_r <= mag(bus.src_a, ~bus.op_code[0]);
      dvs_r <= mag(bus.src_b, ~bus.op_code[0]);
    end else if (div_run_s) begin
      rem_r <= rem_n_s;
      quo_r <= quo_n_s;
    end
  end

  // HI/LO: written only at result commit or by mthi/mtlo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (commit_mul_s) begin
      hi_r <= prod_s[63:32];
      lo_r <= prod_s[31:0];
    end else if (commit_div_s) begin
      hi_r <= div_hi_s;
      lo_r <= div_lo_s;
    end else if (wr_hi_s) begin
      hi_r <= bus.src_a;
    end else if (wr_lo_s) begin
      lo_r <= bus.src_a;
    end
  end

  assign bus.stallreq = ~rst &
                        (((state_r == ST_IDLE) & bus.op_valid & ~bus.flush & ~bus.op_code[2]) |
                         (state_r == ST_MUL) | (state_r == ST_DIV));
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl (MUL_STAGES=2, DIV_STEP=1).
// Inputs change on the falling edge; outputs are sampled 1ns after it.
module tb_mdu_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mdu_if bus ();

  mdu_ctrl #(.MUL_STAGES(2), .DIV_STEP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one long op and hold it until done; report stall, busy and done timing.
  task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int busys, output int done_at);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.src_a    = a;
    bus.src_b    = b;
    stalls  = 0;
    busys   = 0;
    done_at = -1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bus.stallreq) stalls++;
      if (bus.busy) busys++;
      if (bus.done) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    if (done_at < 0) chk("op_timeout", 64'd0, 64'd1);
  endtask

  task automatic div_case(input string tag, input logic [2:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int s, bz, d;
    run_op(code, a, b, s, bz, d);
    chk({tag, "_stall"}, 64'(s), 64'd33);
    chk({tag, "_done_at"}, 64'(d), 64'd33);
    chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    int s, bz, d;
    logic [31:0] hold_hi, hold_lo;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
    bus.src_a    = 32'd0;
    bus.src_b    = 32'd0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    rst = 1'b0;

    // mthi then mtlo back to back: no stall, each visible one cycle later.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 3'b100;
    bus.src_a    = 32'h0000_DEAD;
    #1;
    chk("mthi_stall", {63'd0, bus.stallreq}, 64'd0);
    @(negedge clk);
    #1;
    chk("mthi_hi", {32'd0, bus.hi}, 64'h0000_DEAD);
    chk("mthi_done", {63'd0, bus.done}, 64'd0);
    bus.op_code = 3'b101;
    bus.src_a   = 32'h0000_BEEF;
    #1;
    chk("mtlo_stall", {63'd0, bus.stallreq}, 64'd0);
    @(negedge clk);
    #1;
    chk("mtlo_lo", {32'd0, bus.lo}, 64'h0000_BEEF);
    chk("mtlo_hi_kept", {32'd0, bus.hi}, 64'h0000_DEAD);
    chk("mtlo_busy", {63'd0, bus.busy}, 64'd0);
    bus.op_valid = 1'b0;

    // multu max*max: 3 stall cycles, done in the 4th.
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s, bz, d);
    chk("multu_stall", 64'(s), 64'd3);
    chk("multu_busy", 64'(bz), 64'd2);
    chk("multu_done_at", 64'(d), 64'd3);
    chk("multu_hi", {32'd0, bus.hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'd0, bus.lo}, 64'h0000_0001);

    // mult signed: -3 * 5 = -15.
    run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, s, bz, d);
    chk("mult_done_at", 64'(d), 64'd3);
    chk("mult_prod", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    div_case("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    div_case("div_7_m2", 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    div_case("divu_100_7", 3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
    div_case("divu_big", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC);
    div_case("divu_by0", 3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
    div_case("div_by0", 3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    div_case("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Reserved op code: no stall, no state change, HI/LO untouched.
    hold_hi = bus.hi;
    hold_lo = bus.lo;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 3'b110;
    bus.src_a    = 32'h5555_5555;
    #1;
    chk("rsv_stall", {63'd0, bus.stallreq}, 64'd0);
    @(negedge clk);
    #1;
    chk("rsv_busy", {63'd0, bus.busy}, 64'd0);
    chk("rsv_hi", {32'd0, bus.hi}, {32'd0, hold_hi});
    chk("rsv_lo", {32'd0, bus.lo}, {32'd0, hold_lo});
    bus.op_valid = 1'b0;

    // Flush on the 10th DIV cycle: back to IDLE, no done, HI/LO kept.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 3'b010;
    bus.src_a    = 32'h0000_0064;
    bus.src_b    = 32'h0000_0003;
    repeat (10) @(negedge clk);
    #1;
    chk("flush_busy_before", {63'd0, bus.busy}, 64'd1);
    bus.flush    = 1'b1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush_busy_after", {63'd0, bus.busy}, 64'd0);
    chk("flush_stall_after", {63'd0, bus.stallreq}, 64'd0);
    d = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) d++;
      @(negedge clk);
      #1;
    end
    chk("flush_no_done", 64'(d), 64'd0);
    chk("flush_hi", {32'd0, bus.hi}, {32'd0, hold_hi});
    chk("flush_lo", {32'd0, bus.lo}, {32'd0, hold_lo});

    // Op presented together with flush in IDLE is not accepted.
    bus.op_valid = 1'b1;
    bus.op_code  = 3'b000;
    bus.flush    = 1'b1;
    #1;
    chk("flush_idle_stall", {63'd0, bus.stallreq}, 64'd0);
    @(negedge clk);
    #1;
    chk("flush_idle_busy", {63'd0, bus.busy}, 64'd0);
    bus.op_code = 3'b100;
    bus.src_a   = 32'h1111_1111;
    @(negedge clk);
    #1;
    chk("flush_idle_mthi", {32'd0, bus.hi}, {32'd0, hold_hi});
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;

    // Asynchronous reset in mid-multiply clears everything at once.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 3'b001;
    bus.src_a    = 32'h0000_0007;
    bus.src_b    = 32'h0000_0009;
    @(negedge clk);
    #1;
    chk("arst_busy_before", {63'd0, bus.busy}, 64'd1);
    #2;
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    #1;
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_stall", {63'd0, bus.stallreq}, 64'd0);
    chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("arst_no_commit", {bus.hi, bus.lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
